al_dram_fifo_ctrl: RTL and testbench
====================================

AL_DRAM_FIFO_CTRL -- requirements
Module: al_dram_fifo_ctrl

Interface
REQ-001 SHALL take parameter AFULL_LEVEL, default 12, almost_full asserts when count >= AFULL_LEVEL (1..16).
REQ-002 SHALL take parameter AEMPTY_LEVEL, default 2, almost_empty asserts when count <= AEMPTY_LEVEL (0..15).
REQ-003 SHALL take parameters INIT_D0..INIT_D3, default 16'h0000, passed unchanged to the storage instance.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port flush, input, 1: synchronous empty request.
REQ-007 Port in_valid, input, 1: producer has a word.
REQ-008 Port in_data, input, 4: producer word.
REQ-009 Port in_ready, output, 1: controller accepts a word this cycle.
REQ-010 Port out_valid, output, 1: head word available.
REQ-011 Port out_data, output, 4: head word.
REQ-012 Port out_ready, input, 1: consumer takes the head word this cycle.
REQ-013 Port count, output, 5: occupancy, 0..16.
REQ-014 Port full / empty / almost_full / almost_empty, output, 1 each: status flags.
REQ-015 Port overflow / underflow, output, 1 each: sticky error flags.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal !full && !flush; out_valid SHALL equal !empty; full = (count==16); empty = (count==0).
REQ-018 On push: the RAM write port SHALL get we=1, waddr=wptr, di=in_data; wptr SHALL increment mod 16 (15 -> 0).
REQ-019 raddr SHALL be rptr continuously; out_data SHALL be the combinational RAM read at rptr (show-ahead); on pop rptr SHALL increment mod 16.
REQ-020 Latency: a word pushed at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N, when it is the head.
REQ-021 count SHALL update +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 Full: push is not accepted even if a pop occurs in the same cycle; in_ready stays 0 until count < 16.
REQ-023 Empty: a pop cannot occur; a push into an empty FIFO SHALL leave out_valid=0 in that cycle.
REQ-024 overflow SHALL set when in_valid && full, and underflow when out_ready && empty; both hold until rst or flush.
REQ-025 flush SHALL take priority over push/pop: wptr, rptr and count go to 0 and errors clear at the next edge; RAM contents are not cleared.
REQ-026 we SHALL never be 1 while flush or rst is high.
REQ-027 All flags SHALL derive from the registered count; no combinational path from in_valid to out_valid.

Reset
REQ-028 rst SHALL force wptr=0, rptr=0, count=0, overflow=0 and underflow=0 at the next clk edge.
REQ-029 During reset: in_ready=0, out_valid=0, empty=1, full=0, almost_empty=1, almost_full=0.
REQ-030 Reset mid-operation SHALL abandon stored words; a push in the reset cycle is discarded.

Structure
REQ-031 Shared package SHALL hold DEPTH=16, AW=4, DW=4 and CW=5.
REQ-032 One sub-module SHALL be used: the 16x4 distributed DRAM primitive AL_LOGIC_DRAM16X4, with wclk=clk.
REQ-033 Pointers and count SHALL be the only state, in one clocked process plus flag logic.

Verification
REQ-034 Reset, then push 0x1,0x2,0x3 with no pop -> count=3, out_data=0x1, almost_empty=0, empty=0.
REQ-035 Push 16 words 0x0..0xF -> full=1, in_ready=0; a 17th push with in_valid=1 -> overflow=1 and count stays 16.
REQ-036 Hold full, then assert in_valid and out_ready together -> pop only; count=15; the next cycle accepts the push.
REQ-037 Stream 40 words with push and pop every cycle starting at count=5 -> count constant 5, in-order data, pointers wrap 15->0 with no loss.
REQ-038 count=9, assert flush with in_valid=1 -> next cycle count=0, empty=1, and the word is not stored.
REQ-039 count=7, assert rst for 1 cycle with out_ready=1 -> count=0, out_valid=0, underflow=0 after release.

Source files
------------

// File: rtl/al_dram_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// al_dram_fifo_ctrl_pkg
// Shared sizing constants and helper types for the 16-entry, 4-bit-wide
// show-ahead FIFO controller built on a 16x4 distributed DRAM.
//   DEPTH : number of storage words
//   AW    : RAM address / pointer width
//   DW    : data word width
//   CW    : occupancy counter width (must hold 0..DEPTH)
// ---------------------------------------------------------------------------
package al_dram_fifo_ctrl_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int CW    = 5;

  // What the FIFO does to its occupancy in a given cycle.
  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } fifoOp_e;

  // Collapse the accepted push/pop handshakes into a single operation code
  // so the counter update reads as one case statement.
  function automatic fifoOp_e decodeOp(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   decodeOp = OP_PUSH;
      2'b01:   decodeOp = OP_POP;
      2'b11:   decodeOp = OP_BOTH;
      default: decodeOp = OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/al_dram_fifo_ctrl_dram.sv
// ---------------------------------------------------------------------------
// AL_LOGIC_DRAM16X4
// Behavioural model of the 16x4 distributed DRAM primitive: one synchronous
// write port and one asynchronous (combinational) read port.
// Ports:
//   di    : write data
//   waddr : write address
//   wclk  : write clock, writes on rising edge
//   we    : write enable
//   raddr : read address
//   dout  : combinational read data at raddr
// Parameters INIT_D0..INIT_D3 give the power-up contents, one 16-bit plane
// per data bit: bit a of INIT_Dk is data bit k at address a.
// ---------------------------------------------------------------------------
module AL_LOGIC_DRAM16X4
  import al_dram_fifo_ctrl_pkg::*;
#(
  parameter logic [15:0] INIT_D0 = 16'h0000,
  parameter logic [15:0] INIT_D1 = 16'h0000,
  parameter logic [15:0] INIT_D2 = 16'h0000,
  parameter logic [15:0] INIT_D3 = 16'h0000
) (
  input  logic [DW-1:0] di,
  input  logic [AW-1:0] waddr,
  input  logic          wclk,
  input  logic          we,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout
);

  // Storage is kept as one bit-plane per data bit so the INIT parameters
  // map directly onto the power-up contents, just like the vendor cell.
  logic [DEPTH-1:0] plane_q [DW] = '{INIT_D0, INIT_D1, INIT_D2, INIT_D3};

  // Synchronous write: every bit-plane captures its data bit at waddr.
  always_ff @(posedge wclk) begin
    if (we) begin
      for (int b = 0; b < DW; b++) begin
        plane_q[b][waddr] <= di[b];
      end
    end
  end

  // Asynchronous read: the word at raddr is visible in the same cycle,
  // which is what gives the controller its show-ahead behaviour.
  always_comb begin
    dout = '0;
    for (int b = 0; b < DW; b++) begin
      dout[b] = plane_q[b][raddr];
    end
  end

endmodule

// File: rtl/al_dram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// al_dram_fifo_ctrl
// 16-deep, 4-bit show-ahead FIFO controller around a 16x4 distributed DRAM.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   flush               : synchronous empty request, wins over push/pop
//   in_valid, in_data   : producer side; in_ready says the word is taken
//   out_valid, out_data : head word (combinational RAM read at rptr)
//   out_ready           : consumer takes the head word this cycle
//   count               : occupancy 0..16
//   full, empty, almost_full, almost_empty : status flags from count
//   overflow, underflow : sticky error flags, cleared by rst or flush
// ---------------------------------------------------------------------------
module al_dram_fifo_ctrl
  import al_dram_fifo_ctrl_pkg::*;
#(
  parameter int          AFULL_LEVEL  = 12,
  parameter int          AEMPTY_LEVEL = 2,
  parameter logic [15:0] INIT_D0      = 16'h0000,
  parameter logic [15:0] INIT_D1      = 16'h0000,
  parameter logic [15:0] INIT_D2      = 16'h0000,
  parameter logic [15:0] INIT_D3      = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          countFull, countEmpty;
  logic          push, pop;
  fifoOp_e       op;

  // Flags come only from the registered count. While rst is high the
  // outward flags are forced to their idle/empty values so nothing can be
  // pushed or popped during the reset cycle, whatever count still holds.
  assign countFull    = (count_q == DEPTH_C);
  assign countEmpty   = (count_q == '0);
  assign full         = !rst && countFull;
  assign empty        = rst || countEmpty;
  assign almost_full  = !rst && (count_q >= AFULL_C);
  assign almost_empty = rst || (count_q <= AEMPTY_C);
  assign in_ready     = !rst && !flush && !countFull;
  assign out_valid    = !empty;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign op           = decodeOp(push, pop);

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Next-state for pointers, count and sticky errors. Pointers wrap for
  // free at AW bits. Flush is applied last so it overrides any push/pop
  // and error setting in the same cycle; RAM contents are left alone.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (in_valid && countFull) begin
      overflow_d = 1'b1;
    end
    if (out_ready && countEmpty) begin
      underflow_d = 1'b1;
    end
    if (flush) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // The only state of the controller: pointers, occupancy and the two
  // sticky error bits, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage: write port driven only by accepted pushes (never during rst
  // or flush, since in_ready is low then), read port tracks rptr.
  AL_LOGIC_DRAM16X4 #(
    .INIT_D0(INIT_D0),
    .INIT_D1(INIT_D1),
    .INIT_D2(INIT_D2),
    .INIT_D3(INIT_D3)
  ) uRam (
    .di   (in_data),
    .waddr(wrPtr_q),
    .wclk (clk),
    .we   (push),
    .raddr(rdPtr_q),
    .dout (out_data)
  );

endmodule

// File: tb/tb_al_dram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_al_dram_fifo_ctrl
// Self-checking bench for al_dram_fifo_ctrl. A queue-based model of the
// FIFO is updated on every rising edge from the applied inputs; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add hand-computed literal checks, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_al_dram_fifo_ctrl;
  import al_dram_fifo_ctrl_pkg::*;

  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int assertCount = 0;
  int failCount   = 0;

  logic [DW-1:0] modelQ[$];
  bit            modelOvf = 1'b0;
  bit            modelUnf = 1'b0;
  bit            checkEn  = 1'b0;

  always #5 clk = ~clk;

  al_dram_fifo_ctrl #(
    .AFULL_LEVEL (AFULL),
    .AEMPTY_LEVEL(AEMPTY),
    .INIT_D0     (16'h1234),
    .INIT_D1     (16'hA5C3),
    .INIT_D2     (16'h0F0F),
    .INIT_D3     (16'hFFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Single comparison point: every check in the bench goes through here.
  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Model of the FIFO as a plain queue: at each rising edge, reset/flush
  // empty it, otherwise a pop takes the front when non-empty and a push
  // appends when the FIFO was not full before the edge.
  always @(posedge clk) begin : modelUpdate
    int n;
    n = modelQ.size();
    if (rst || flush) begin
      modelQ.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
    end else begin
      if (in_valid && n == DEPTH) modelOvf = 1'b1;
      if (out_ready && n == 0) modelUnf = 1'b1;
      if (out_ready && n > 0) void'(modelQ.pop_front());
      if (in_valid && n < DEPTH) modelQ.push_back(in_data);
    end
  end

  // Expected outputs follow from the queue length and the current rst/flush.
  task automatic checkOutput();
    int n;
    n = modelQ.size();
    checkValue("count", 32'(count), 32'(n));
    checkValue("in_ready", 32'(in_ready), 32'(!rst && !flush && n < DEPTH));
    checkValue("out_valid", 32'(out_valid), 32'(!rst && n > 0));
    checkValue("empty", 32'(empty), 32'(rst || n == 0));
    checkValue("full", 32'(full), 32'(!rst && n == DEPTH));
    checkValue("almost_full", 32'(almost_full), 32'(!rst && n >= AFULL));
    checkValue("almost_empty", 32'(almost_empty), 32'(rst || n <= AEMPTY));
    checkValue("overflow", 32'(overflow), 32'(modelOvf));
    checkValue("underflow", 32'(underflow), 32'(modelUnf));
    if (!rst && n > 0) begin
      checkValue("out_data", 32'(out_data), 32'(modelQ[0]));
    end
  endtask

  // Compare against the model away from the rising edge.
  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  // Drive one cycle of inputs, then return just after the edge that
  // sampled them.
  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [DW-1:0] d, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pushHeavy;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    // Reset state while rst is still high.
    checkValue("rst_count", 32'(count), 32'd0);
    checkValue("rst_empty", 32'(empty), 32'd1);
    checkValue("rst_in_ready", 32'(in_ready), 32'd0);
    checkValue("rst_almost_empty", 32'(almost_empty), 32'd1);
    checkValue("rst_full", 32'(full), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);

    // Three pushes, no pop.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    checkValue("three_count", 32'(count), 32'd3);
    checkValue("three_out_data", 32'(out_data), 32'h1);
    checkValue("three_almost_empty", 32'(almost_empty), 32'd0);
    checkValue("three_empty", 32'(empty), 32'd0);

    // Fill to 16, then a 17th push.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'(i), 1'b0);
    end
    checkValue("fill_full", 32'(full), 32'd1);
    checkValue("fill_in_ready", 32'(in_ready), 32'd0);
    checkValue("fill_count", 32'(count), 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h9, 1'b0);
    checkValue("ovf_flag", 32'(overflow), 32'd1);
    checkValue("ovf_count", 32'(count), 32'd16);

    // Full with push and pop together: only the pop happens.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hA, 1'b1);
    checkValue("fullpp_count", 32'(count), 32'd15);
    checkValue("fullpp_head", 32'(out_data), 32'h1);
    checkValue("fullpp_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hA, 1'b0);
    checkValue("refill_count", 32'(count), 32'd16);

    // Drain everything (model checks order 1..F then A), then underflow.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    end
    checkValue("drain_count", 32'(count), 32'd0);
    checkValue("drain_ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    checkValue("unf_flag", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    checkValue("flush_clr_ovf", 32'(overflow), 32'd0);
    checkValue("flush_clr_unf", 32'(underflow), 32'd0);

    // Stream 40 words at constant occupancy 5 across pointer wrap.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'(i + 10), 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'($urandom), 1'b1);
      checkValue("stream_count", 32'(count), 32'd5);
    end

    // Flush at count 9 while a push is offered.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'($urandom), 1'b0);
    end
    checkValue("pre_flush_count", 32'(count), 32'd9);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hE, 1'b0);
    checkValue("flush_count", 32'(count), 32'd0);
    checkValue("flush_empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    checkValue("post_flush_count", 32'(count), 32'd1);
    checkValue("post_flush_head", 32'(out_data), 32'h3);

    // Reset mid-operation at count 7 with out_ready and a push offered.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'(i + 4), 1'b0);
    end
    checkValue("pre_rst_count", 32'(count), 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h5, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    checkValue("midrst_count", 32'(count), 32'd0);
    checkValue("midrst_out_valid", 32'(out_valid), 32'd0);
    checkValue("midrst_underflow", 32'(underflow), 32'd0);

    // Randomized traffic with alternating push-heavy / pop-heavy phases.
    pushHeavy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) pushHeavy = !pushHeavy;
      applyStimulus(($urandom_range(99) < 1),
                    ($urandom_range(99) < 2),
                    ($urandom_range(99) < (pushHeavy ? 85 : 30)),
                    4'($urandom),
                    ($urandom_range(99) < (pushHeavy ? 30 : 85)));
    end

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
